// File: rtl/pin_collision_scanner.sv
// Scans the 10-pin rack against sampled ball positions, one pin per cycle.
// It knocks down hit pins and reports the end of each roll.
module pin_collision_scanner #(
  parameter int PIN_BASE_X   = 700,
  parameter int PIN_CENTER_Y = 200,
  parameter int ROW_DX       = 40,
  parameter int HALF_DY      = 20,
  parameter int HIT_RADIUS   = 12
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] ball_x,
  input  logic [9:0]  ball_y,
  input  logic        check_collision,
  input  logic        done,
  input  logic        new_frame,
  output logic [9:0]  pins_standing,
  output logic [3:0]  pins_down_count,
  output logic        hit_valid,
  output logic [3:0]  hit_index,
  output logic        busy,
  output logic        result_valid
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  localparam logic signed [11:0] RAD = 12'(HIT_RADIUS);

  state_t       state, state_next;
  logic [10:0]  snap_x;
  logic [9:0]   snap_y;
  logic         snap_valid;
  logic         report_pending;
  logic         done_d;
  logic [3:0]   idx;

  logic         done_edge;
  logic         capture;
  logic         pin_hit;
  logic [11:0]  cur_px;
  logic [11:0]  cur_py;
  logic signed [11:0] dx;
  logic signed [11:0] dy;

  // Rack order: row 0 = {0}, row 1 = {1,2}, row 2 = {3,4,5}, row 3 = {6..9}.
  function automatic int row_of(input logic [3:0] k);
    if (k == 4'd0)      return 0;
    else if (k < 4'd3)  return 1;
    else if (k < 4'd6)  return 2;
    else                return 3;
  endfunction

  function automatic logic [11:0] pin_x_of(input logic [3:0] k);
    return 12'(PIN_BASE_X + row_of(k) * ROW_DX);
  endfunction

  function automatic logic [11:0] pin_y_of(input logic [3:0] k);
    int r;
    int s;
    r = row_of(k);
    s = int'(k) - (r * (r + 1)) / 2;
    return 12'(PIN_CENTER_Y + (2 * s - r) * HALF_DY);
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (new_frame) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (done_edge) state_next = REPORT;
                 else if (capture) state_next = SCAN;
        SCAN:    if (idx == 4'd9) state_next = (report_pending || done_edge) ? REPORT : IDLE;
        REPORT:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    done_edge = done && !done_d;
    capture   = check_collision && (!snap_valid || ball_x != snap_x || ball_y != snap_y);
    cur_px    = pin_x_of(idx);
    cur_py    = pin_y_of(idx);
    dx        = $signed({1'b0, snap_x}) - $signed(cur_px);
    dy        = $signed({2'b00, snap_y}) - $signed(cur_py);
    pin_hit   = (state == SCAN) && pins_standing[idx]
                && (dx <= RAD) && (dx >= -RAD) && (dy <= RAD) && (dy >= -RAD);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pins_standing   <= '1;
      pins_down_count <= '0;
      hit_valid       <= 1'b0;
      hit_index       <= '0;
      busy            <= 1'b0;
      result_valid    <= 1'b0;
      snap_x          <= '0;
      snap_y          <= '0;
      snap_valid      <= 1'b0;
      report_pending  <= 1'b0;
      done_d          <= 1'b0;
      idx             <= '0;
    end else begin
      done_d       <= done;
      hit_valid    <= 1'b0;
      result_valid <= 1'b0;
      if (new_frame) begin
        pins_standing   <= '1;
        pins_down_count <= '0;
        busy            <= 1'b0;
        snap_valid      <= 1'b0;
        report_pending  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!done_edge && capture) begin
              snap_x     <= ball_x;
              snap_y     <= ball_y;
              snap_valid <= 1'b1;
              idx        <= '0;
              busy       <= 1'b1;
            end
          end
          SCAN: begin
            if (pin_hit) begin
              pins_standing[idx] <= 1'b0;
              pins_down_count    <= pins_down_count + 4'd1;
              hit_valid          <= 1'b1;
              hit_index          <= idx;
            end
            if (done_edge) report_pending <= 1'b1;
            if (idx == 4'd9) busy <= 1'b0;
            else             idx  <= idx + 4'd1;
          end
          REPORT: begin
            result_valid   <= 1'b1;
            report_pending <= 1'b0;
            snap_valid     <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pin_collision_scanner.sv
// Directed bench for pin_collision_scanner: hit timing, boundaries, roll reporting, frame re-rack.
module tb_pin_collision_scanner;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] ball_x;
  logic [9:0]  ball_y;
  logic        check_collision;
  logic        done;
  logic        new_frame;
  logic [9:0]  pins_standing;
  logic [3:0]  pins_down_count;
  logic        hit_valid;
  logic [3:0]  hit_index;
  logic        busy;
  logic        result_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hit_cyc[$];
  int hit_idx[$];
  int res_cyc[$];

  pin_collision_scanner dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .ball_x          (ball_x),
    .ball_y          (ball_y),
    .check_collision (check_collision),
    .done            (done),
    .new_frame       (new_frame),
    .pins_standing   (pins_standing),
    .pins_down_count (pins_down_count),
    .hit_valid       (hit_valid),
    .hit_index       (hit_index),
    .busy            (busy),
    .result_valid    (result_valid)
  );

  always #5 clk_in = ~clk_in;

  // Pulse log, sampled mid-cycle; cyc numbers the cycle that started at the last posedge.
  always @(negedge clk_in) begin
    if (hit_valid) begin
      hit_cyc.push_back(cyc);
      hit_idx.push_back(int'(hit_index));
    end
    if (result_valid) res_cyc.push_back(cyc);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      cyc++;
    end
  endtask

  task automatic clear_logs();
    hit_cyc.delete();
    hit_idx.delete();
    res_cyc.delete();
  endtask

  task automatic rerack();
    new_frame = 1'b1;
    tick(1);
    new_frame = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; ball_x = 11'd700; ball_y = 10'd200;
    check_collision = 1'b0; done = 1'b0; new_frame = 1'b0;
    tick(2);
    rst_in = 1'b0;
    clear_logs();
    total++; if (pins_standing !== 10'h3FF) begin bad++; $display("FAIL reset_pins actual=%h expected=3ff", pins_standing); end
    total++; if (pins_down_count !== 4'd0) begin bad++; $display("FAIL reset_count actual=%0d expected=0", pins_down_count); end
    total++; if ({hit_valid, hit_index, busy, result_valid} !== 7'd0) begin bad++;
      $display("FAIL reset_flags actual=%b expected=0000000", {hit_valid, hit_index, busy, result_valid}); end
    tick(6);
    total++; if (hit_cyc.size() != 0 || res_cyc.size() != 0 || busy !== 1'b0) begin bad++;
      $display("FAIL reset_idle hits=%0d results=%0d busy=%b expected 0/0/0", hit_cyc.size(), res_cyc.size(), busy); end
    total++; if (pins_standing !== 10'h3FF) begin bad++; $display("FAIL reset_idle_pins actual=%h expected=3ff", pins_standing); end
  endtask

  task automatic test_head_pin();
    int c;
    clear_logs();
    ball_x = 11'd705; ball_y = 10'd195; check_collision = 1'b1;
    c = cyc;
    tick(1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL head_busy_start actual=%b expected=1", busy); end
    tick(9);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL head_busy_last actual=%b expected=1", busy); end
    tick(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL head_busy_end actual=%b expected=0", busy); end
    tick(12);
    total++; if (hit_cyc.size() != 1) begin bad++; $display("FAIL head_hit_count actual=%0d expected=1", hit_cyc.size()); end
    else begin
      total++; if (hit_cyc[0] != c + 2 || hit_idx[0] != 0) begin bad++;
        $display("FAIL head_hit actual=cyc%0d/pin%0d expected=cyc%0d/pin0", hit_cyc[0], hit_idx[0], c + 2); end
    end
    total++; if (pins_standing !== 10'h3FE || pins_down_count !== 4'd1) begin bad++;
      $display("FAIL head_state actual=%h/%0d expected=3fe/1", pins_standing, pins_down_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL head_no_rescan busy=%b expected=0", busy); end
    check_collision = 1'b0;
    tick(1);
  endtask

  task automatic test_boundary();
    int c;
    rerack();
    clear_logs();
    ball_x = 11'd712; ball_y = 10'd212; check_collision = 1'b1;
    c = cyc;
    tick(14);
    total++; if (hit_cyc.size() != 1 || pins_standing !== 10'h3FE) begin bad++;
      $display("FAIL bound_corner hits=%0d pins=%h expected 1/3fe", hit_cyc.size(), pins_standing); end
    else begin
      total++; if (hit_cyc[0] != c + 2 || hit_idx[0] != 0) begin bad++;
        $display("FAIL bound_corner_hit actual=cyc%0d/pin%0d expected=cyc%0d/pin0", hit_cyc[0], hit_idx[0], c + 2); end
    end
    check_collision = 1'b0;
    rerack();
    total++; if (pins_standing !== 10'h3FF || pins_down_count !== 4'd0) begin bad++;
      $display("FAIL bound_rerack actual=%h/%0d expected=3ff/0", pins_standing, pins_down_count); end
    clear_logs();
    ball_x = 11'd713; ball_y = 10'd200; check_collision = 1'b1;
    tick(14);
    total++; if (hit_cyc.size() != 0 || pins_standing !== 10'h3FF) begin bad++;
      $display("FAIL bound_outside hits=%0d pins=%h expected 0/3ff", hit_cyc.size(), pins_standing); end
    check_collision = 1'b0;
    rerack();
    clear_logs();
    ball_x = 11'd820; ball_y = 10'd260; check_collision = 1'b1;
    c = cyc;
    tick(14);
    total++; if (hit_cyc.size() != 1) begin bad++; $display("FAIL bound_pin9_count actual=%0d expected=1", hit_cyc.size()); end
    else begin
      total++; if (hit_cyc[0] != c + 11 || hit_idx[0] != 9) begin bad++;
        $display("FAIL bound_pin9 actual=cyc%0d/pin%0d expected=cyc%0d/pin9", hit_cyc[0], hit_idx[0], c + 11); end
    end
    total++; if (pins_standing !== 10'h1FF || pins_down_count !== 4'd1) begin bad++;
      $display("FAIL bound_pin9_state actual=%h/%0d expected=1ff/1", pins_standing, pins_down_count); end
    check_collision = 1'b0;
    tick(1);
  endtask

  task automatic test_multi_roll();
    int c1, c2, c3, d;
    rerack();
    clear_logs();
    ball_x = 11'd700; ball_y = 10'd200; check_collision = 1'b1;
    c1 = cyc;
    tick(12);
    ball_x = 11'd780; ball_y = 10'd200;
    c2 = cyc;
    tick(12);
    ball_x = 11'd820; ball_y = 10'd180;
    c3 = cyc;
    tick(12);
    check_collision = 1'b0;
    total++; if (hit_cyc.size() != 3) begin bad++; $display("FAIL roll_hit_count actual=%0d expected=3", hit_cyc.size()); end
    else begin
      total++; if (hit_idx[0] != 0 || hit_idx[1] != 4 || hit_idx[2] != 7) begin bad++;
        $display("FAIL roll_order actual=%0d,%0d,%0d expected=0,4,7", hit_idx[0], hit_idx[1], hit_idx[2]); end
      total++; if (hit_cyc[0] != c1 + 2 || hit_cyc[1] != c2 + 6 || hit_cyc[2] != c3 + 9) begin bad++;
        $display("FAIL roll_timing actual=%0d,%0d,%0d expected=%0d,%0d,%0d",
                 hit_cyc[0], hit_cyc[1], hit_cyc[2], c1 + 2, c2 + 6, c3 + 9); end
    end
    total++; if (pins_standing !== 10'h36E || pins_down_count !== 4'd3) begin bad++;
      $display("FAIL roll_state actual=%h/%0d expected=36e/3", pins_standing, pins_down_count); end
    done = 1'b1;
    d = cyc;
    tick(6);
    total++; if (res_cyc.size() != 1) begin bad++; $display("FAIL roll_result_count actual=%0d expected=1", res_cyc.size()); end
    else begin
      total++; if (res_cyc[0] != d + 2) begin bad++; $display("FAIL roll_result_cyc actual=%0d expected=%0d", res_cyc[0], d + 2); end
    end
    total++; if (pins_down_count !== 4'd3) begin bad++; $display("FAIL roll_final_count actual=%0d expected=3", pins_down_count); end
    done = 1'b0;
    tick(2);
  endtask

  task automatic test_done_mid_scan();
    int c;
    rerack();
    clear_logs();
    ball_x = 11'd740; ball_y = 10'd180; check_collision = 1'b1;
    c = cyc;
    tick(4);
    done = 1'b1;
    tick(7);
    check_collision = 1'b0;
    tick(5);
    total++; if (hit_cyc.size() != 1) begin bad++; $display("FAIL mid_hit_count actual=%0d expected=1", hit_cyc.size()); end
    else begin
      total++; if (hit_cyc[0] != c + 3 || hit_idx[0] != 1) begin bad++;
        $display("FAIL mid_hit actual=cyc%0d/pin%0d expected=cyc%0d/pin1", hit_cyc[0], hit_idx[0], c + 3); end
    end
    total++; if (res_cyc.size() != 1) begin bad++; $display("FAIL mid_result_count actual=%0d expected=1", res_cyc.size()); end
    else begin
      total++; if (res_cyc[0] != c + 12) begin bad++; $display("FAIL mid_result_cyc actual=%0d expected=%0d", res_cyc[0], c + 12); end
    end
    total++; if (pins_standing !== 10'h3FD || pins_down_count !== 4'd1) begin bad++;
      $display("FAIL mid_state actual=%h/%0d expected=3fd/1", pins_standing, pins_down_count); end
    done = 1'b0;
    tick(2);
  endtask

  task automatic test_frame_reset_mid_scan();
    int c;
    rerack();
    clear_logs();
    ball_x = 11'd820; ball_y = 10'd140; check_collision = 1'b1;
    c = cyc;
    tick(3);
    new_frame = 1'b1;
    tick(1);
    new_frame = 1'b0;
    total++; if (pins_standing !== 10'h3FF || pins_down_count !== 4'd0 || busy !== 1'b0) begin bad++;
      $display("FAIL frame_abort actual=%h/%0d/busy%b expected=3ff/0/busy0", pins_standing, pins_down_count, busy); end
    tick(1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL frame_recapture busy=%b expected=1", busy); end
    tick(15);
    check_collision = 1'b0;
    total++; if (hit_cyc.size() != 1) begin bad++; $display("FAIL frame_hit_count actual=%0d expected=1", hit_cyc.size()); end
    else begin
      total++; if (hit_cyc[0] != c + 12 || hit_idx[0] != 6) begin bad++;
        $display("FAIL frame_hit actual=cyc%0d/pin%0d expected=cyc%0d/pin6", hit_cyc[0], hit_idx[0], c + 12); end
    end
    total++; if (pins_standing !== 10'h3BF || pins_down_count !== 4'd1) begin bad++;
      $display("FAIL frame_state actual=%h/%0d expected=3bf/1", pins_standing, pins_down_count); end
    total++; if (res_cyc.size() != 0) begin bad++; $display("FAIL frame_no_result actual=%0d expected=0", res_cyc.size()); end
  endtask

  initial begin
    test_reset();
    test_head_pin();
    test_boundary();
    test_multi_roll();
    test_done_mid_scan();
    test_frame_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
